// File: rtl/io_input_conditioner.sv
// Input conditioner for a bidirectional I/O pin: synchronises the raw pin sample,
// debounces it with a stability counter and derives edge strobes and an edge count.
module io_input_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 8,
    parameter int unsigned EDGE_SEL        = 0,
    parameter bit          RESET_LEVEL     = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             pin_in,
    input  logic             cnt_clr,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] event_count,
    output logic             busy
);

    // Wide enough for the largest legal debounce length.
    localparam int unsigned DbW = 16;

    typedef enum logic [0:0] {
        StStable,
        StQualify
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sample;

    state_e                 state_q, state_d;
    logic [DbW-1:0]         db_cnt_q, db_cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   count_hit;
    logic                   strobe_sel;

    // Synchroniser chain; shifts every clock independent of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_in};
        end
    end

    assign sample    = sync_q[SYNC_STAGES-1];
    assign count_hit = (db_cnt_q == DbW'(DEBOUNCE_CYCLES));

    // State register plus the registered level, strobes and edge counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StStable;
            db_cnt_q <= '0;
            level_q  <= RESET_LEVEL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            db_cnt_q <= db_cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            count_q  <= count_d;
        end
    end

    // Next-state logic: qualify a differing sample for DEBOUNCE_CYCLES before accepting it.
    always_comb begin
        state_d  = state_q;
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (!en) begin
            // Disabling abandons any qualification in progress.
            state_d  = StStable;
            db_cnt_d = '0;
        end else begin
            unique case (state_q)
                StStable: begin
                    if (sample != level_q) begin
                        state_d  = StQualify;
                        db_cnt_d = DbW'(1);
                    end
                end
                StQualify: begin
                    if (sample == level_q) begin
                        // Glitch: the sample fell back before it was qualified.
                        state_d  = StStable;
                        db_cnt_d = '0;
                    end else if (count_hit) begin
                        state_d  = StStable;
                        db_cnt_d = '0;
                        level_d  = sample;
                        rise_d   = sample;
                        fall_d   = ~sample;
                    end else begin
                        db_cnt_d = db_cnt_q + DbW'(1);
                    end
                end
                default: begin
                    state_d  = StStable;
                    db_cnt_d = '0;
                end
            endcase
        end
    end

    // Edge counter next value; clear wins over a coincident counted strobe.
    always_comb begin
        strobe_sel = (rise_d && (EDGE_SEL != 1)) || (fall_d && (EDGE_SEL != 0));
        count_d    = count_q;
        if (cnt_clr) begin
            count_d = '0;
        end else if (strobe_sel) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Outputs, all taken straight from registers.
    always_comb begin
        busy        = (state_q == StQualify);
        level       = level_q;
        rise        = rise_q;
        fall        = fall_q;
        event_count = count_q;
    end

endmodule

// File: tb/tb_io_input_conditioner.sv
// Self-checking bench for io_input_conditioner: three differently parameterised
// instances share stimulus and are compared every cycle against a run-length model.
module tb_io_input_conditioner;

    localparam int unsigned SYNC [3] = '{2, 3, 4};
    localparam int unsigned DEB  [3] = '{16, 3, 1};
    localparam int unsigned CW   [3] = '{8, 2, 3};
    localparam int unsigned ESEL [3] = '{0, 2, 1};
    localparam bit          RL   [3] = '{1'b0, 1'b1, 1'b0};
    localparam int          WRAP [5] = '{1, 2, 3, 0, 1};

    logic clk = 1'b0;
    logic rst_n, en, pin_in, cnt_clr;
    logic lvl_o [3];
    logic rise_o [3];
    logic fall_o [3];
    logic busy_o [3];
    logic [7:0] cnt0;
    logic [1:0] cnt1;
    logic [2:0] cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit m_sync [3][4];
    bit m_lvl [3];
    int m_run [3];
    bit m_rise [3];
    bit m_fall [3];
    int m_cnt [3];

    always #5 clk = ~clk;

    io_input_conditioner #(
        .SYNC_STAGES(SYNC[0]), .DEBOUNCE_CYCLES(DEB[0]), .CNT_W(CW[0]),
        .EDGE_SEL(ESEL[0]), .RESET_LEVEL(RL[0])
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .pin_in(pin_in), .cnt_clr(cnt_clr),
        .level(lvl_o[0]), .rise(rise_o[0]), .fall(fall_o[0]), .event_count(cnt0),
        .busy(busy_o[0])
    );

    io_input_conditioner #(
        .SYNC_STAGES(SYNC[1]), .DEBOUNCE_CYCLES(DEB[1]), .CNT_W(CW[1]),
        .EDGE_SEL(ESEL[1]), .RESET_LEVEL(RL[1])
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .pin_in(pin_in), .cnt_clr(cnt_clr),
        .level(lvl_o[1]), .rise(rise_o[1]), .fall(fall_o[1]), .event_count(cnt1),
        .busy(busy_o[1])
    );

    io_input_conditioner #(
        .SYNC_STAGES(SYNC[2]), .DEBOUNCE_CYCLES(DEB[2]), .CNT_W(CW[2]),
        .EDGE_SEL(ESEL[2]), .RESET_LEVEL(RL[2])
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .pin_in(pin_in), .cnt_clr(cnt_clr),
        .level(lvl_o[2]), .rise(rise_o[2]), .fall(fall_o[2]), .event_count(cnt2),
        .busy(busy_o[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_cnt(input int k);
        case (k)
            0:       return 32'(cnt0);
            1:       return 32'(cnt1);
            default: return 32'(cnt2);
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) m_sync[k][i] = RL[k];
            m_lvl[k]  = RL[k];
            m_run[k]  = 0;
            m_rise[k] = 1'b0;
            m_fall[k] = 1'b0;
            m_cnt[k]  = 0;
        end
    endtask

    // One clock edge: the level flips once the synchronised sample has disagreed with it
    // on DEB+1 consecutive enabled edges.
    task automatic model_edge(input bit p, input bit e, input bit c);
        for (int k = 0; k < 3; k++) begin
            bit smp, r, f;
            smp = m_sync[k][SYNC[k]-1];
            for (int i = 3; i > 0; i--) m_sync[k][i] = m_sync[k][i-1];
            m_sync[k][0] = p;
            r = 1'b0;
            f = 1'b0;
            if (e && smp != m_lvl[k]) begin
                m_run[k]++;
                if (m_run[k] == int'(DEB[k]) + 1) begin
                    r = smp;
                    f = !smp;
                    m_lvl[k] = smp;
                    m_run[k] = 0;
                end
            end else begin
                m_run[k] = 0;
            end
            if (c) m_cnt[k] = 0;
            else if ((r && ESEL[k] != 1) || (f && ESEL[k] != 0))
                m_cnt[k] = (m_cnt[k] + 1) % (1 << CW[k]);
            m_rise[k] = r;
            m_fall[k] = f;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("level%0d", k), 32'(lvl_o[k]), 32'(m_lvl[k]));
            check($sformatf("rise%0d", k), 32'(rise_o[k]), 32'(m_rise[k]));
            check($sformatf("fall%0d", k), 32'(fall_o[k]), 32'(m_fall[k]));
            check($sformatf("busy%0d", k), 32'(busy_o[k]), 32'(m_run[k] > 0));
            check($sformatf("count%0d", k), dut_cnt(k), 32'(m_cnt[k]));
        end
    endtask

    task automatic step();
        bit p, e, c;
        p = pin_in;
        e = en;
        c = cnt_clr;
        @(posedge clk);
        if (rst_n) model_edge(p, e, c);
        #1;
        check_all();
    endtask

    task automatic async_reset();
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int idx;
        int hold;
        bit saw;

        pin_in  = 1'b1;
        en      = 1'b1;
        cnt_clr = 1'b0;
        rst_n   = 1'b0;
        model_reset();

        // Reset held with pin high
        repeat (3) step();
        check("rst_level", 32'(lvl_o[0]), 0);
        check("rst_count", 32'(cnt0), 0);
        check("rst_level_rl1", 32'(lvl_o[1]), 1);
        #2 rst_n = 1'b1;

        // First rise exactly SYNC+DEB+1 edges after release
        for (int i = 1; i <= 19; i++) begin
            step();
            check("rise_timing", 32'(rise_o[0]), 32'(i == 19));
        end
        check("count_after_rise", 32'(cnt0), 1);

        // Falling step: not counted with rising-edge selection
        pin_in = 1'b0;
        repeat (25) step();
        check("level_after_fall", 32'(lvl_o[0]), 0);
        check("count_after_fall", 32'(cnt0), 1);

        // 15-cycle glitch rejected
        saw = 1'b0;
        pin_in = 1'b1;
        repeat (15) begin step(); saw |= rise_o[0]; end
        pin_in = 1'b0;
        repeat (25) begin step(); saw |= rise_o[0]; end
        check("glitch_strobe", 32'(saw), 0);
        check("glitch_level", 32'(lvl_o[0]), 0);
        check("glitch_busy", 32'(busy_o[0]), 0);
        pin_in = 1'b1;
        repeat (25) step();
        check("long_high_level", 32'(lvl_o[0]), 1);

        // Enable dropped at qualification cycle 10
        pin_in = 1'b0;
        repeat (12) step();
        check("qual_busy", 32'(busy_o[0]), 1);
        en = 1'b0;
        repeat (20) begin
            step();
            check("dis_busy", 32'(busy_o[0]), 0);
            check("dis_level", 32'(lvl_o[0]), 1);
        end
        en = 1'b1;
        n = 0;
        while (n < 40) begin
            step();
            n++;
            if (lvl_o[0] == 1'b0) break;
        end
        check("reenable_latency", 32'(n), 17);

        // Clear coincident with a counted strobe
        pin_in = 1'b1;
        repeat (18) step();
        check("pre_clr_rise", 32'(rise_o[0]), 0);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("clr_rise", 32'(rise_o[0]), 1);
        check("clr_count", 32'(cnt0), 0);

        // Async reset at qualification cycle 8
        pin_in = 1'b0;
        repeat (25) step();
        pin_in = 1'b1;
        repeat (10) step();
        check("pre_rst_busy", 32'(busy_o[0]), 1);
        async_reset();
        check("mid_rst_busy", 32'(busy_o[0]), 0);
        check("mid_rst_level", 32'(lvl_o[0]), 0);
        repeat (2) step();
        #2 rst_n = 1'b1;
        for (int i = 1; i <= 19; i++) begin
            step();
            check("rise_after_rst", 32'(rise_o[0]), 32'(i == 19));
        end

        // Wrap on the 2-bit, both-edges instance
        idx = 0;
        for (int t = 0; t < 5; t++) begin
            pin_in = (t % 2 == 0) ? 1'b0 : 1'b1;
            repeat (30) begin
                step();
                if (rise_o[1] || fall_o[1]) begin
                    if (idx < 5) check("wrap_seq", dut_cnt(1), 32'(WRAP[idx]));
                    idx++;
                end
            end
        end
        check("wrap_edges", 32'(idx), 5);

        // Randomised phase
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                pin_in = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 24);
            end
            hold--;
            en      = ($urandom_range(0, 99) < 95);
            cnt_clr = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 999) < 3) begin
                async_reset();
                #1 rst_n = 1'b1;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
